uart_rx_cfg: RTL and testbench

Parametrised successor to the fixed 8-bit UART receiver. It adds configurable data width, a runtime-selectable 1 or 2 stop bits, a 2-flop input synchroniser, 3-sample majority voting, and explicit parity and framing error pulses. It sits between the serial pin and the SoC-side byte consumer and produces one parallel word per valid frame.

---
 rtl/uart_rx_cfg_pkg.sv | 18 +
 rtl/uart_rx_cfg_if.sv | 26 ++
 rtl/uart_rx_cfg_sampler.sv | 44 ++++
 rtl/uart_rx_cfg.sv | 149 ++++++++++++++
 tb/tb_uart_rx_cfg.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_LEN_MIN = 5;
  localparam int DATA_LEN_MAX = 9;

  // Out-of-range lengths fall back to the full word width.
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (int'(len) < DATA_LEN_MIN || int'(len) > max_len) return 4'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial line, frame configuration and received-word outputs of uart_rx_cfg.
interface uart_rx_cfg_if #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
);
  logic               RX_IN;
  logic [PRESC_W-1:0] PRESCALE;
  logic [3:0]         DATA_LEN;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic               STOP2;
  logic [DATA_W-1:0]  P_DATA;
  logic               DATA_VALID;
  logic               PAR_ERR;
  logic               STP_ERR;

  modport master (
    output RX_IN, PRESCALE, DATA_LEN, PAR_EN, PAR_TYP, STOP2,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PRESCALE, DATA_LEN, PAR_EN, PAR_TYP, STOP2,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_cfg_sampler.sv
// Per-bit edge counter with a 3-sample majority vote around the bit centre.
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               rx_s_i,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic               sample_o,
  output logic               dec_o,
  output logic               bit_end_o
);
  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d, mid;
  logic [1:0]         smp_q, smp_d;

  assign mid = prescale_i >> 1;

  always_comb begin
    edge_cnt_d = '0;
    if (en_i && edge_cnt_q != prescale_i - ONE) edge_cnt_d = edge_cnt_q + ONE;
    smp_d = smp_q;
    if (edge_cnt_q == mid - ONE) smp_d[0] = rx_s_i;
    if (edge_cnt_q == mid)       smp_d[1] = rx_s_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

  // Third sample is taken live so the vote is ready at mid+1.
  assign sample_o  = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_i) | (smp_q[1] & rx_s_i);
  assign dec_o     = en_i && (edge_cnt_q == mid + ONE);
  assign bit_end_o = en_i && (edge_cnt_q == prescale_i - ONE);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with configurable length, parity and stop bits; one word per valid frame.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PRESC_W     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_cfg_if.slave  bus
);
  rx_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [3:0]             len_q, len_d, bit_cnt_q, bit_cnt_d;
  logic                   par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic [DATA_W-1:0]      data_q, data_d, p_data_q, p_data_d;
  logic                   par_bad_q, par_bad_d, stp_bad_q, stp_bad_d, armed_q, armed_d;
  logic                   valid_q, valid_d, perr_q, perr_d, serr_q, serr_d;
  logic                   sample, dec, bit_end, start_go, frame_end, stp_fin;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk        (CLK),
    .rst_n      (RST),
    .en_i       (state_q != IDLE),
    .rx_s_i     (rx_s),
    .prescale_i (presc_q),
    .sample_o   (sample),
    .dec_o      (dec),
    .bit_end_o  (bit_end)
  );

  // A break frame disarms IDLE until the line has been seen high again.
  assign start_go  = (state_q == IDLE) && armed_q && !rx_s;
  assign frame_end = (state_q == STOP) && dec && (!stop2_q || bit_cnt_q == 4'd1);
  assign stp_fin   = stp_bad_q | ~sample;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = START;
      START:   if (dec && sample) state_d = IDLE;
               else if (bit_end)  state_d = DATA;
      DATA:    if (bit_end && bit_cnt_q == len_q - 4'd1) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d   = presc_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    data_d    = data_q;
    par_bad_d = par_bad_q;
    stp_bad_d = stp_bad_q;
    armed_d   = armed_q;
    p_data_d  = p_data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
    if (state_d != state_q) bit_cnt_d = '0;
    else if (bit_end)       bit_cnt_d = bit_cnt_q + 4'd1;
    if (start_go) begin
      presc_d   = bus.PRESCALE;
      len_d     = clamp_len(bus.DATA_LEN, DATA_W);
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
      stop2_d   = bus.STOP2;
      data_d    = '0;
      par_bad_d = 1'b0;
      stp_bad_d = 1'b0;
    end
    if (state_q == IDLE && rx_s) armed_d = 1'b1;
    if (state_q == DATA && dec) begin
      for (int i = 0; i < DATA_W; i++)
        if (bit_cnt_q == 4'(i)) data_d[i] = sample;
    end
    if (state_q == PARITY && dec) par_bad_d = ((^data_q) ^ sample) != par_typ_q;
    if (state_q == STOP && dec && !sample) stp_bad_d = 1'b1;
    if (frame_end) begin
      if (!par_bad_q && !stp_fin) begin
        valid_d  = 1'b1;
        p_data_d = data_q;
      end else begin
        perr_d = par_bad_q;
        serr_d = stp_fin;
        if (stp_fin) armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q   <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      par_bad_q <= 1'b0;
      stp_bad_q <= 1'b0;
      armed_q   <= 1'b1;
      p_data_q  <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      data_q    <= data_d;
      par_bad_q <= par_bad_d;
      stp_bad_q <= stp_bad_d;
      armed_q   <= armed_d;
      p_data_q  <= p_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.PAR_ERR    = perr_q;
  assign bus.STP_ERR    = serr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_cfg;
  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;

  typedef struct packed {
    logic              v;
    logic              pe;
    logic              se;
    logic [DATA_W-1:0] d;
  } ev_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_rx_cfg_if #(.DATA_W(DATA_W), .PRESC_W(PRESC_W)) bus ();

  uart_rx_cfg #(.DATA_W(DATA_W), .PRESC_W(PRESC_W), .SYNC_STAGES(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  ev_t got_q[$];
  ev_t exp_q[$];
  logic [DATA_W-1:0] last_good;
  int cur_p, cfg_len;
  bit cfg_pe, cfg_pt, cfg_s2;

  always @(negedge CLK)
    if (RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR))
      got_q.push_back('{v: bus.DATA_VALID, pe: bus.PAR_ERR, se: bus.STP_ERR, d: bus.P_DATA});

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not end, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic string ev_str(input ev_t e);
    return $sformatf("{valid=%0b par_err=%0b stp_err=%0b data=%h}", e.v, e.pe, e.se, e.d);
  endfunction

  function automatic ev_t ev_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return '0;
  endfunction

  function automatic int eff_len(input int len);
    return (len < 5 || len > DATA_W) ? DATA_W : len;
  endfunction

  task automatic set_cfg(input int p, input int len, input bit pe, input bit pt, input bit s2);
    cur_p = p; cfg_len = len; cfg_pe = pe; cfg_pt = pt; cfg_s2 = s2;
    bus.PRESCALE = PRESC_W'(p);
    bus.DATA_LEN = 4'(len);
    bus.PAR_EN   = pe;
    bus.PAR_TYP  = pt;
    bus.STOP2    = s2;
  endtask

  task automatic drive_bit(input bit v);
    bus.RX_IN = v;
    repeat (cur_p) @(posedge CLK);
    #1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  // Frame-level model: outcome follows from the bits put on the line.
  task automatic send_frame(input logic [7:0] data, input bit par_bit, input bit s1, input bit s2,
                            input int gap, input bit scramble);
    int n;
    logic [DATA_W-1:0] word;
    bit perr, serr, good_par;
    ev_t e;
    n = eff_len(cfg_len);
    word = '0;
    for (int i = 0; i < n; i++) word[i] = data[i];
    good_par = bit'(($countones(word) + int'(cfg_pt)) % 2);
    perr = cfg_pe && (par_bit != good_par);
    serr = !s1 || (cfg_s2 && !s2);
    if (!perr && !serr) begin
      e = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: word};
      last_good = word;
    end else begin
      e = '{v: 1'b0, pe: perr, se: serr, d: last_good};
    end
    exp_q.push_back(e);
    drive_bit(1'b0);
    if (scramble) begin
      bus.PRESCALE = PRESC_W'($urandom);
      bus.DATA_LEN = 4'($urandom);
      bus.PAR_EN   = 1'($urandom);
      bus.PAR_TYP  = 1'($urandom);
      bus.STOP2    = 1'($urandom);
    end
    for (int i = 0; i < n; i++) drive_bit(data[i]);
    if (cfg_pe) drive_bit(par_bit);
    drive_bit(s1);
    if (cfg_s2) drive_bit(s2);
    repeat (gap) drive_bit(1'b1);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA} !== '0) begin
      errors++;
      $display("FAIL reset_in got valid=%b perr=%b serr=%b data=%h, required all 0",
               bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA);
    end
    RST = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA} !== '0) begin
      errors++;
      $display("FAIL reset_out got valid=%b perr=%b serr=%b data=%h, required all 0",
               bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA);
    end
  endtask

  task automatic test_even_parity();
    ev_t want;
    set_cfg(8, 8, 1'b1, 1'b0, 1'b0);
    got_q.delete();
    send_frame(8'hA9, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    want = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'hA9};
    checks++;
    if (got_q.size() != 1) begin
      errors++; $display("FAIL even_count got %0d events, required 1", got_q.size());
    end
    checks++;
    if (ev_at(0) !== want) begin
      errors++; $display("FAIL even_event got %s, required %s", ev_str(ev_at(0)), ev_str(want));
    end
  endtask

  task automatic test_odd_parity();
    ev_t want0, want1;
    set_cfg(8, 8, 1'b1, 1'b1, 1'b0);
    got_q.delete();
    send_frame(8'hAB, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    send_frame(8'hAB, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    want0 = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'hAB};
    want1 = '{v: 1'b0, pe: 1'b1, se: 1'b0, d: 8'hAB};
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL odd_count got %0d events, required 2", got_q.size());
    end
    checks++;
    if (ev_at(0) !== want0) begin
      errors++; $display("FAIL odd_good got %s, required %s", ev_str(ev_at(0)), ev_str(want0));
    end
    checks++;
    if (ev_at(1) !== want1) begin
      errors++; $display("FAIL odd_parerr got %s, required %s", ev_str(ev_at(1)), ev_str(want1));
    end
  endtask

  task automatic test_stop2();
    ev_t want0, want1;
    set_cfg(8, 7, 1'b0, 1'b0, 1'b1);
    got_q.delete();
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 3, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    want0 = '{v: 1'b0, pe: 1'b0, se: 1'b1, d: 8'hAB};
    want1 = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'h55};
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL stop2_count got %0d events, required 2", got_q.size());
    end
    checks++;
    if (ev_at(0) !== want0) begin
      errors++; $display("FAIL stop2_err got %s, required %s", ev_str(ev_at(0)), ev_str(want0));
    end
    checks++;
    if (ev_at(1) !== want1) begin
      errors++; $display("FAIL stop2_good got %s, required %s", ev_str(ev_at(1)), ev_str(want1));
    end
  endtask

  task automatic test_glitch();
    ev_t want;
    set_cfg(16, 8, 1'b0, 1'b0, 1'b0);
    got_q.delete();
    bus.RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle_bits(3);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL glitch_quiet got %0d events, required 0", got_q.size());
    end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    want = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'h3C};
    checks++;
    if (got_q.size() != 1 || ev_at(0) !== want) begin
      errors++; $display("FAIL glitch_next got %0d events first %s, required 1 event %s",
                         got_q.size(), ev_str(ev_at(0)), ev_str(want));
    end
  endtask

  task automatic test_back_to_back();
    ev_t want0, want1;
    set_cfg(8, 8, 1'b1, 1'b0, 1'b0);
    got_q.delete();
    send_frame(8'h12, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    want0 = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'h12};
    want1 = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'h34};
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL b2b_count got %0d events, required 2", got_q.size());
    end
    checks++;
    if (ev_at(0) !== want0 || ev_at(1) !== want1) begin
      errors++; $display("FAIL b2b_events got %s %s, required %s %s",
                         ev_str(ev_at(0)), ev_str(ev_at(1)), ev_str(want0), ev_str(want1));
    end
  endtask

  task automatic test_reset_abort();
    ev_t want;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    got_q.delete();
    drive_bit(1'b0);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    bus.RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (bus.P_DATA !== '0 || bus.DATA_VALID !== 1'b0) begin
      errors++; $display("FAIL abort_reset got data=%h valid=%b, required 00 0", bus.P_DATA, bus.DATA_VALID);
    end
    RST = 1'b1;
    last_good = '0;
    idle_bits(4);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL abort_quiet got %0d events, required 0", got_q.size());
    end
    send_frame(8'hF0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    want = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'hF0};
    checks++;
    if (got_q.size() != 1 || ev_at(0) !== want) begin
      errors++; $display("FAIL abort_next got %0d events first %s, required 1 event %s",
                         got_q.size(), ev_str(ev_at(0)), ev_str(want));
    end
  endtask

  task automatic test_break();
    ev_t want0, want1;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    got_q.delete();
    repeat (14) drive_bit(1'b0);
    idle_bits(3);
    want0 = '{v: 1'b0, pe: 1'b0, se: 1'b1, d: last_good};
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    want1 = '{v: 1'b1, pe: 1'b0, se: 1'b0, d: 8'h81};
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL break_count got %0d events, required 2", got_q.size());
    end
    checks++;
    if (ev_at(0) !== want0 || ev_at(1) !== want1) begin
      errors++; $display("FAIL break_events got %s %s, required %s %s",
                         ev_str(ev_at(0)), ev_str(ev_at(1)), ev_str(want0), ev_str(want1));
    end
  endtask

  task automatic test_random();
    int len, gap;
    bit pe, pt, s2, s1b, s2b, par_bit;
    logic [7:0] data;
    logic [DATA_W-1:0] word;
    got_q.delete();
    exp_q.delete();
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(5, 8));
      pe  = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      set_cfg(2 * int'($urandom_range(3, 10)), len, pe, pt, s2);
      data = 8'($urandom);
      word = '0;
      for (int i = 0; i < eff_len(len); i++) word[i] = data[i];
      par_bit = bit'(($countones(word) + int'(pt)) % 2);
      if ($urandom_range(0, 4) == 0) par_bit = ~par_bit;
      s1b = ($urandom_range(0, 5) != 0);
      s2b = ($urandom_range(0, 5) != 0);
      gap = int'($urandom_range(0, 2));
      if (!s1b || (s2 && !s2b)) gap = gap + 1;
      send_frame(data, par_bit, s1b, s2b, gap, 1'b1);
    end
    idle_bits(3);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d events, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (ev_at(i) !== exp_q[i]) begin
        errors++; $display("FAIL rand_event[%0d] got %s, required %s", i, ev_str(ev_at(i)), ev_str(exp_q[i]));
      end
    end
  endtask

  initial begin
    RST = 1'b0;
    bus.RX_IN = 1'b1;
    last_good = '0;
    set_cfg(8, 8, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_stop2();
    test_glitch();
    test_back_to_back();
    test_reset_abort();
    test_break();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
